// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stall, jump, call/return through a circular
// return-address stack, with sticky RAS overflow/underflow flags.
module pc_sequencer #(
  parameter int ADDR_W    = 10,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           Reset_n,
  input  logic                           Stall,
  input  logic                           Jump,
  input  logic                           Call,
  input  logic                           Ret,
  input  logic [ADDR_W-1:0]              JumpTo,
  output logic [ADDR_W-1:0]              Address,
  output logic [ADDR_W-1:0]              Previous,
  output logic [$clog2(RAS_DEPTH):0]     Ras_Count,
  output logic                           Ras_Overflow,
  output logic                           Ras_Underflow
);

  localparam int IDX_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_VEC);
  localparam logic [CNT_W-1:0]  FULL_V  = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] prev_r;
  logic [ADDR_W-1:0] ras_r [RAS_DEPTH];
  logic [IDX_W-1:0]  sp_r;
  logic [CNT_W-1:0]  count_r;
  logic              ovf_r;
  logic              unf_r;

  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [ADDR_W-1:0] next_prev_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              set_unf_s;

  // Next-action selection: Call > Jump > Ret > Stall > increment.
  always_comb begin
    seq_s       = addr_r + STEP_V;
    top_idx_s   = sp_r - IDX_W'(1);
    full_s      = (count_r == FULL_V);
    next_addr_s = addr_r;
    next_prev_s = prev_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    set_unf_s   = 1'b0;
    if (Call) begin
      push_s      = 1'b1;
      next_addr_s = JumpTo;
      next_prev_s = addr_r;
    end else if (Jump) begin
      next_addr_s = JumpTo;
      next_prev_s = addr_r;
    end else if (Ret) begin
      next_prev_s = addr_r;
      if (count_r != {CNT_W{1'b0}}) begin
        pop_s       = 1'b1;
        next_addr_s = ras_r[top_idx_s];
      end else begin
        set_unf_s   = 1'b1;
        next_addr_s = seq_s;
      end
    end else if (Stall) begin
      next_addr_s = addr_r;
      next_prev_s = prev_r;
    end else begin
      next_addr_s = seq_s;
      next_prev_s = addr_r;
    end
  end

  // State update; a push onto a full stack lands on the oldest slot.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_r  <= RESET_V;
      prev_r  <= RESET_V;
      sp_r    <= {IDX_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      addr_r <= next_addr_s;
      prev_r <= next_prev_s;
      unf_r  <= unf_r | set_unf_s;
      if (push_s) begin
        ras_r[sp_r] <= seq_s;
        sp_r        <= sp_r + IDX_W'(1);
        if (full_s) begin
          ovf_r <= 1'b1;
        end else begin
          count_r <= count_r + CNT_W'(1);
        end
      end else if (pop_s) begin
        sp_r    <= top_idx_s;
        count_r <= count_r - CNT_W'(1);
      end else begin
        sp_r    <= sp_r;
        count_r <= count_r;
      end
    end
  end

  assign Address       = addr_r;
  assign Previous      = prev_r;
  assign Ras_Count     = count_r;
  assign Ras_Overflow  = ovf_r;
  assign Ras_Underflow = unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based model checked every cycle,
// plus hand-computed expectations at the test-plan milestones.
module tb_pc_sequencer;

  localparam int AW = 10;
  localparam int DEPTH = 4;

  logic          clk;
  logic          Reset_n;
  logic          Stall, Jump, Call, Ret;
  logic [AW-1:0] JumpTo;
  logic [AW-1:0] Address, Previous;
  logic [2:0]    Ras_Count;
  logic          Ras_Overflow, Ras_Underflow;

  pc_sequencer #(.ADDR_W(AW), .STEP(1), .RESET_VEC(0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .Reset_n(Reset_n), .Stall(Stall), .Jump(Jump), .Call(Call),
    .Ret(Ret), .JumpTo(JumpTo), .Address(Address), .Previous(Previous),
    .Ras_Count(Ras_Count), .Ras_Overflow(Ras_Overflow),
    .Ras_Underflow(Ras_Underflow)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [AW-1:0] m_addr, m_prev;
  logic [AW-1:0] m_ras[$];
  logic          m_ovf, m_unf;
  logic          check_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = '0;
    m_prev = '0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Apply one edge's worth of request according to the priority rules.
  task automatic model_edge(input logic c, input logic j, input logic r,
                            input logic s, input logic [AW-1:0] jt);
    logic [AW-1:0] nxt;
    nxt = m_addr + 10'd1;
    if (c) begin
      m_ras.push_back(nxt);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_prev = m_addr; m_addr = jt;
    end else if (j) begin
      m_prev = m_addr; m_addr = jt;
    end else if (r) begin
      m_prev = m_addr;
      if (m_ras.size() > 0) m_addr = m_ras.pop_back();
      else begin m_unf = 1'b1; m_addr = nxt; end
    end else if (!s) begin
      m_prev = m_addr; m_addr = nxt;
    end
  endtask

  // Drive one request from a negedge, advance one edge, return at the next negedge.
  task automatic step(input logic c, input logic j, input logic r,
                      input logic s, input int jt);
    Call = c; Jump = j; Ret = r; Stall = s; JumpTo = AW'(jt);
    @(posedge clk);
    model_edge(c, j, r, s, AW'(jt));
    @(negedge clk);
    Call = 1'b0; Jump = 1'b0; Ret = 1'b0; Stall = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("addr", int'(Address), int'(m_addr));
      chk("prev", int'(Previous), int'(m_prev));
      chk("ras_count", int'(Ras_Count), m_ras.size());
      chk("ovf", int'(Ras_Overflow), int'(m_ovf));
      chk("unf", int'(Ras_Underflow), int'(m_unf));
    end
  end

  initial begin
    Reset_n = 1'b0; Stall = 1'b0; Jump = 1'b0; Call = 1'b0; Ret = 1'b0;
    JumpTo = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_addr", int'(Address), 0);
    chk("reset_count", int'(Ras_Count), 0);
    Reset_n = 1'b1;
    check_en = 1'b1;

    // 1: free-running
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t1_addr", int'(Address), 5);
    chk("t1_prev", int'(Previous), 4);

    // 2: stall at 7
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("t2_stall_addr", int'(Address), 7);
    chk("t2_stall_prev", int'(Previous), 6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t2_rel_addr", int'(Address), 8);
    chk("t2_rel_prev", int'(Previous), 7);

    // 3: call / return
    step(1'b0, 1'b1, 1'b0, 1'b0, 20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 100);
    chk("t3_call_addr", int'(Address), 100);
    chk("t3_call_count", int'(Ras_Count), 1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t3_ret_addr", int'(Address), 21);
    chk("t3_ret_prev", int'(Previous), 103);
    chk("t3_ret_count", int'(Ras_Count), 0);

    // 4: overflow then underflow
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 10 * i);
    chk("t4_ovf", int'(Ras_Overflow), 1);
    chk("t4_count", int'(Ras_Count), 4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t4_ret1", int'(Address), 41);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t4_ret4", int'(Address), 11);
    chk("t4_unf_before", int'(Ras_Underflow), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t4_ret5", int'(Address), 12);
    chk("t4_unf", int'(Ras_Underflow), 1);
    chk("t4_count0", int'(Ras_Count), 0);

    // 5: simultaneous requests
    step(1'b1, 1'b1, 1'b1, 1'b1, 300);
    chk("t5_call_addr", int'(Address), 300);
    chk("t5_call_count", int'(Ras_Count), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5);
    chk("t5_jump_addr", int'(Address), 5);
    chk("t5_jump_count", int'(Ras_Count), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("t5_ret_stall", int'(Address), 13);

    // 6: wrap-around and mid-run reset
    step(1'b0, 1'b1, 1'b0, 1'b0, 1023);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t6_wrap_addr", int'(Address), 0);
    chk("t6_wrap_prev", int'(Previous), 1023);
    step(1'b1, 1'b0, 1'b0, 1'b0, 77);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    #2;
    check_en = 1'b0;
    Reset_n = 1'b0;
    Call = 1'bx; Jump = 1'bx; Ret = 1'bx; Stall = 1'bx; JumpTo = 'x;
    #1;
    chk("t6_rst_addr", int'(Address), 0);
    chk("t6_rst_prev", int'(Previous), 0);
    chk("t6_rst_count", int'(Ras_Count), 0);
    chk("t6_rst_ovf", int'(Ras_Overflow), 0);
    chk("t6_rst_unf", int'(Ras_Underflow), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("t6_rst_x_addr", int'(Address), 0);
    chk("t6_rst_x_count", int'(Ras_Count), 0);
    @(negedge clk);
    Call = 1'b0; Jump = 1'b0; Ret = 1'b0; Stall = 1'b0; JumpTo = '0;
    Reset_n = 1'b1;
    check_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t6_post_addr", int'(Address), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t6_post_ret", int'(Address), 2);
    chk("t6_post_unf", int'(Ras_Underflow), 1);
    check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
